// File: rtl/note_lane_renderer.sv
// Redraws one lane's note block: erases the previous frame's block, then draws the new one.
// Every output is registered and is computed from next-state values, so pixel 0 appears in the
// first ERASE cycle.
module note_lane_renderer #(
  parameter logic [8:0]  LANE_X      = 9'd40,
  parameter int unsigned NOTE_W      = 16,
  parameter int unsigned NOTE_H      = 8,
  parameter logic [2:0]  NOTE_COLOUR = 3'b110,
  parameter logic [2:0]  BG_COLOUR   = 3'b000,
  parameter int unsigned SCREEN_H    = 240
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [7:0] note_y,
  input  logic       note_valid,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = (NOTE_W > 1) ? $clog2(NOTE_W) : 1;
  localparam int unsigned RW = (NOTE_H > 1) ? $clog2(NOTE_H) : 1;
  localparam logic [CW-1:0] ColLast = CW'(NOTE_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(NOTE_H - 1);

  typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    cur_y_q, cur_y_d, prev_y_q, prev_y_d;
  logic          cur_valid_q, cur_valid_d, prev_valid_q, prev_valid_d;

  logic [8:0] vga_x_d;
  logic [7:0] vga_y_d;
  logic [2:0] vga_colour_d;
  logic       plot_d, busy_d, done_d;
  logic [8:0] row_sum;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      cur_y_q      <= '0;
      prev_y_q     <= '0;
      cur_valid_q  <= 1'b0;
      prev_valid_q <= 1'b0;
      vga_x        <= '0;
      vga_y        <= '0;
      vga_colour   <= '0;
      plot         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cur_y_q      <= cur_y_d;
      prev_y_q     <= prev_y_d;
      cur_valid_q  <= cur_valid_d;
      prev_valid_q <= prev_valid_d;
      vga_x        <= vga_x_d;
      vga_y        <= vga_y_d;
      vga_colour   <= vga_colour_d;
      plot         <= plot_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    cur_y_d      = cur_y_q;
    prev_y_d     = prev_y_q;
    cur_valid_d  = cur_valid_q;
    prev_valid_d = prev_valid_q;
    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d     = StErase;
          col_d       = '0;
          row_d       = '0;
          cur_y_d     = note_y;
          cur_valid_d = note_valid;
        end
      end
      StErase, StDraw: begin
        if (col_q == ColLast) begin
          col_d = '0;
          if (row_q == RowLast) begin
            row_d   = '0;
            state_d = (state_q == StErase) ? StDraw : StDone;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StDone: begin
        prev_y_d     = cur_y_q;
        prev_valid_d = cur_valid_q;
        state_d      = StIdle;
      end
    endcase
  end

  // Row sum is 9 bits so rows past the screen bottom are clipped rather than wrapped.
  always_comb begin
    row_sum      = ((state_d == StDraw) ? {1'b0, cur_y_d} : {1'b0, prev_y_d}) + 9'(row_d);
    vga_x_d      = '0;
    vga_y_d      = '0;
    vga_colour_d = '0;
    plot_d       = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    unique case (state_d)
      StIdle: ;
      StErase: begin
        vga_x_d      = LANE_X + 9'(col_d);
        vga_y_d      = row_sum[7:0];
        vga_colour_d = BG_COLOUR;
        plot_d       = prev_valid_d && (32'(row_sum) < SCREEN_H);
        busy_d       = 1'b1;
      end
      StDraw: begin
        vga_x_d      = LANE_X + 9'(col_d);
        vga_y_d      = row_sum[7:0];
        vga_colour_d = NOTE_COLOUR;
        plot_d       = cur_valid_d && (32'(row_sum) < SCREEN_H);
        busy_d       = 1'b1;
      end
      StDone: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_note_lane_renderer.sv
// Scoreboard bench: stimulus queues the expected plots and done pulses; a negedge monitor
// checks each plotted pixel (and its cycle) and each done pulse against the queues.
module tb_note_lane_renderer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] note_y = '0;
  logic       note_valid = 1'b0;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, done;

  note_lane_renderer dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .note_y     (note_y),
    .note_valid (note_valid),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } px_t;

  px_t  px_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [7:0] m_prev_y = '0;
  logic       m_prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Monitor: every plot and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      n_tests++;
      if (px_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected plot: cyc=%0d x=%0d y=%0d c=%b", cyc, vga_x, vga_y, vga_colour);
      end else begin
        px_t e;
        e = px_q.pop_front();
        if (e.cyc != cyc || e.x !== vga_x || e.y !== vga_y || e.c !== vga_colour) begin
          n_fail++;
          $display("FAIL pixel: got cyc=%0d x=%0d y=%0d c=%b, expected cyc=%0d x=%0d y=%0d c=%b",
                   cyc, vga_x, vga_y, vga_colour, e.cyc, e.x, e.y, e.c);
        end
      end
    end
    if (done === 1'b1) begin
      n_tests++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected done: cyc=%0d", cyc);
      end else begin
        int e;
        e = done_q.pop_front();
        if (e != cyc) begin
          n_fail++;
          $display("FAIL done cycle: got %0d, expected %0d", cyc, e);
        end
      end
    end
  end

  function automatic void push_phase(input int base, input logic [7:0] y0, input logic v,
                                     input logic [2:0] colour);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        int s;
        px_t p;
        s = int'(y0) + r;
        if (v && s < 240) begin
          p.cyc = base + r * 16 + c;
          p.x   = 9'(40 + c);
          p.y   = 8'(s);
          p.c   = colour;
          px_q.push_back(p);
        end
      end
    end
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " vga_x"}, int'(vga_x), 0);
    check({tag, " vga_y"}, int'(vga_y), 0);
    check({tag, " vga_colour"}, int'(vga_colour), 0);
    check({tag, " plot"}, int'(plot), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " done"}, int'(done), 0);
  endtask

  // One redraw: optional ignored ticks at cycles 5 and 257, optional reset at cycle abort_at.
  task automatic redraw(input logic [7:0] y, input logic v, input bit ign, input int abort_at);
    int c0;
    @(negedge clk);
    c0 = cyc;
    push_phase(c0 + 1, m_prev_y, m_prev_valid, 3'b000);
    push_phase(c0 + 129, y, v, 3'b110);
    done_q.push_back(c0 + 257);
    frame_tick = 1'b1;
    note_y     = y;
    note_valid = v;
    for (int i = 1; i <= 262; i++) begin
      @(negedge clk);
      frame_tick = ign && (i == 5 || i == 257);
      if (frame_tick) begin
        note_y     = 8'd99;
        note_valid = 1'b1;
      end
      if (i == 128) check("busy mid-redraw", int'(busy), 1);
      if (i == abort_at) begin
        resetn = 1'b0;
        @(posedge clk);
        #1;
        px_q.delete();
        done_q.delete();
        @(negedge clk);
        check_idle_outputs("after abort");
        resetn       = 1'b1;
        m_prev_y     = '0;
        m_prev_valid = 1'b0;
        return;
      end
    end
    check("busy after done", int'(busy), 0);
    check("pending plots", px_q.size(), 0);
    check("pending done", done_q.size(), 0);
    m_prev_y     = y;
    m_prev_valid = v;
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    resetn = 1'b1;

    redraw(8'd20, 1'b1, 1'b0, 0);   // first draw: no erase plots
    redraw(8'd24, 1'b1, 1'b0, 0);   // erase 20..27, draw 24..31
    redraw(8'd236, 1'b1, 1'b0, 0);  // draw clipped to rows 236..239
    redraw(8'd50, 1'b1, 1'b1, 0);   // stray ticks at 5 and 257 ignored
    redraw(8'd77, 1'b0, 1'b0, 0);   // erase 50..57, nothing drawn
    redraw(8'd10, 1'b1, 1'b0, 0);   // nothing to erase
    redraw(8'd30, 1'b1, 1'b0, 100); // reset mid-erase
    redraw(8'd60, 1'b1, 1'b0, 0);   // no erase after reset
    redraw(8'd60, 1'b1, 1'b0, 0);   // same y: full erase then draw

    repeat (5) @(negedge clk);
    check("final pending plots", px_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/note_lane_renderer.md
NOTE_LANE_RENDERER -- requirements
Module: note_lane_renderer

Interface
REQ-001 Parameter LANE_X, default 40, 9-bit left x of the lane's note block.
REQ-002 Parameter NOTE_W, default 16, block width in pixels.
REQ-003 Parameter NOTE_H, default 8, block height in pixels.
REQ-004 Parameter NOTE_COLOUR, default 3'b110, draw colour.
REQ-005 Parameter BG_COLOUR, default 3'b000, erase colour.
REQ-006 Parameter SCREEN_H, default 240, visible rows; rows at or above this value are clipped.
REQ-007 clk  input  1  system clock; all logic on rising edge.
REQ-008 resetn  input  1  reset, synchronous, active-low.
REQ-009 frame_tick  input  1  one-cycle pulse requesting a redraw of the lane.
REQ-010 note_y  input  8  top row of the note, from the double-buffered y stage (oy).
REQ-011 note_valid  input  1  note present this frame; 0 means lane empty.
REQ-012 vga_x  output  9  pixel x to VGA adapter.
REQ-013 vga_y  output  8  pixel y to VGA adapter.
REQ-014 vga_colour  output  3  pixel colour.
REQ-015 plot  output  1  write strobe; pixel written when high.
REQ-016 busy  output  1  redraw in progress.
REQ-017 done  output  1  one-cycle pulse at end of redraw.

Function
REQ-018 The FSM SHALL have states IDLE, ERASE, DRAW, DONE; all outputs registered.
REQ-019 In IDLE, frame_tick=1 SHALL latch note_y into cur_y and note_valid into cur_valid, clear col/row counters, and enter ERASE next cycle.
REQ-020 frame_tick while busy=1 SHALL be ignored (no queueing, no relatch).
REQ-021 ERASE SHALL visit NOTE_W*NOTE_H pixels row-major, one per cycle: vga_x=LANE_X+col, vga_y=prev_y+row, vga_colour=BG_COLOUR.
REQ-022 DRAW SHALL visit the same pattern at vga_y=cur_y+row with vga_colour=NOTE_COLOUR.
REQ-023 Row sum SHALL be computed 9-bit; if prev_y+row or cur_y+row >= SCREEN_H, plot SHALL be 0 for that pixel and vga_y carries the low 8 bits.
REQ-024 plot SHALL be 0 throughout ERASE when prev_valid=0 and throughout DRAW when cur_valid=0; phase timing SHALL be unchanged (fixed NOTE_W*NOTE_H cycles each).
REQ-025 ERASE->DRAW when col=NOTE_W-1 and row=NOTE_H-1; counters clear on transition; DRAW->DONE likewise.
REQ-026 DONE SHALL last one cycle with done=1, plot=0, copy cur_y->prev_y and cur_valid->prev_valid, then return to IDLE.
REQ-027 Latency: frame_tick accepted in cycle 0; ERASE pixels in cycles 1..W*H; DRAW in W*H+1..2*W*H; done at 2*W*H+1 (257 with defaults).
REQ-028 busy SHALL be 1 in ERASE, DRAW, DONE and 0 in IDLE; frame_tick in the cycle done=1 SHALL be ignored.
REQ-029 Identical cur_y and prev_y SHALL still perform full erase then draw.

Reset
REQ-030 resetn=0 at a clock edge SHALL force IDLE, col=row=0, prev_y=cur_y=0, prev_valid=cur_valid=0, vga_x=vga_y=vga_colour=0, plot=busy=done=0 on the next cycle, aborting any redraw.
REQ-031 After reset the first redraw SHALL perform no erase plots (prev_valid=0).

Verification
REQ-032 Reset, then frame_tick with note_y=20, valid=1 -> 128 cycles plot=0, then 128 plots x 40..55, y 20..27, colour 110, done at cycle 257.
REQ-033 Next frame_tick note_y=24 -> 128 erase plots y 20..27 colour 000, then 128 draw plots y 24..31 colour 110.
REQ-034 note_y=236, valid=1 -> draw plots only for rows 236..239 (64 plots); rows 240..243 plot=0; done still at cycle 257.
REQ-035 frame_tick pulses at cycles 5 and 257 of a redraw -> ignored; exactly one done; prev_y unchanged by ignored ticks.
REQ-036 note_valid=0 after a drawn note at y=50 -> erase plots at y 50..57, zero draw plots; next redraw erases nothing.
REQ-037 resetn=0 at cycle 100 of a redraw -> next cycle all outputs 0, state IDLE; following frame_tick performs no erase plots.
